// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy-table update slice: phase indices, entry layout,
// sequencer state encoding and small helpers.
package enemy_pkg;

  localparam int unsigned ENEMY_ADDR_W = 6;
  localparam int unsigned ENEMY_DATA_W = 24;

  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned COL_LSB   = 1;
  localparam int unsigned COL_MSB   = 12;
  localparam int unsigned ROW_LSB   = 13;
  localparam int unsigned ROW_MSB   = 23;

  typedef logic [ENEMY_ADDR_W-1:0] enemy_addr_t;
  typedef logic [ENEMY_DATA_W-1:0] enemy_entry_t;

  typedef enum logic [1:0] {
    PH_CLEAN  = 2'd0,
    PH_CREATE = 2'd1,
    PH_MOVE   = 2'd2,
    PH_SHOOT  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  function automatic logic entry_valid(enemy_entry_t e);
    return e[VALID_BIT];
  endfunction

  function automatic logic [COL_MSB-COL_LSB:0] entry_col(enemy_entry_t e);
    return e[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [ROW_MSB-ROW_LSB:0] entry_row(enemy_entry_t e);
    return e[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [3:0] phase_onehot(phase_e p);
    return 4'b0001 << p;
  endfunction

  // CREATE only runs when a spawn tick is waiting.
  function automatic phase_e next_phase(phase_e p, logic spawn_pending);
    case (p)
      PH_CLEAN:  return spawn_pending ? PH_CREATE : PH_MOVE;
      PH_CREATE: return PH_MOVE;
      default:   return PH_SHOOT;
    endcase
  endfunction

endpackage

// File: rtl/enemy_phase_sequencer_if.sv
// Handshake bundle between the phase sequencer (master) and the update engines /
// display side (slave).
interface enemy_phase_sequencer_if;
  logic       calc;
  logic [3:0] phase_done;
  logic [3:0] phase_start;
  logic       phase_abort;
  logic [1:0] phase_sel;
  logic       mem_owner;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  logic [1:0] err_phase;

  modport master (
    input  calc, phase_done,
    output phase_start, phase_abort, phase_sel, mem_owner, busy,
           frame_done, timeout_err, err_phase
  );

  modport slave (
    output calc, phase_done,
    input  phase_start, phase_abort, phase_sel, mem_owner, busy,
           frame_done, timeout_err, err_phase
  );
endinterface

// File: rtl/enemy_phase_sequencer_phase_timer.sv
// Per-phase watchdog: clearable up-counter; expire flags the enabled edge on which
// the running phase completes its PHASE_TIMEOUT-1'th cycle.
module phase_timer #(
  parameter int unsigned PHASE_TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = $clog2(PHASE_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(PHASE_TIMEOUT - 2);

  logic [TW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/enemy_phase_sequencer.sv
// Frame-level scheduler for the enemy-table update engines: runs CLEAN, CREATE,
// MOVE, SHOOT once per calc window and owns the enemy-memory port select.
module enemy_phase_sequencer #(
  parameter int unsigned PHASE_TIMEOUT = 256,
  parameter int unsigned SPAWN_PERIOD  = 134217728,
  parameter int unsigned CNT_W         = 32
) (
  input logic                      clock,
  input logic                      reset,
  enemy_phase_sequencer_if.master  seq
);
  import enemy_pkg::*;

  seq_state_e       state;
  phase_e           phase;
  logic             calc_q;
  logic             calc_armed;
  logic [CNT_W-1:0] spawn_cnt;
  logic             spawn_pending;

  logic [3:0] phase_start_r;
  logic       phase_abort_r;
  logic [1:0] phase_sel_r;
  logic       mem_owner_r;
  logic       busy_r;
  logic       frame_done_r;
  logic       timeout_err_r;
  logic [1:0] err_phase_r;

  logic rise;
  logic done_hit;
  logic timer_expire;
  logic spawn_wrap;
  logic create_clear;

  // calc_q alone would see a rise when calc is already high as reset releases;
  // calc_armed requires calc to have been seen low first.
  assign rise         = seq.calc && !calc_q && calc_armed;
  assign done_hit     = (state == ST_RUN) && seq.calc && seq.phase_done[phase];
  assign spawn_wrap   = (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1));
  assign create_clear = done_hit && (phase == PH_CREATE);

  phase_timer #(
    .PHASE_TIMEOUT(PHASE_TIMEOUT)
  ) u_phase_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_LAUNCH),
    .enable (state == ST_RUN),
    .expire (timer_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spawn_cnt     <= '0;
      spawn_pending <= 1'b0;
    end else begin
      spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + 1'b1;
      if (spawn_wrap) begin
        spawn_pending <= 1'b1;
      end else if (create_clear) begin
        spawn_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase         <= PH_CLEAN;
      calc_q        <= 1'b0;
      calc_armed    <= 1'b0;
      phase_start_r <= '0;
      phase_abort_r <= 1'b0;
      phase_sel_r   <= '0;
      mem_owner_r   <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      err_phase_r   <= '0;
    end else begin
      calc_q <= seq.calc;
      if (!seq.calc) begin
        calc_armed <= 1'b1;
      end
      phase_start_r <= '0;
      phase_abort_r <= 1'b0;
      frame_done_r  <= 1'b0;

      case (state)
        ST_IDLE: begin
          mem_owner_r <= 1'b0;
          busy_r      <= 1'b0;
          if (rise) begin
            phase <= PH_CLEAN;
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH, ST_RUN: begin
          if (!seq.calc) begin
            // Window closed early: stop the engine and hand the port back at once.
            phase_abort_r <= 1'b1;
            mem_owner_r   <= 1'b0;
            busy_r        <= 1'b0;
            state         <= ST_IDLE;
          end else if (state == ST_LAUNCH) begin
            phase_start_r <= phase_onehot(phase);
            phase_sel_r   <= phase;
            mem_owner_r   <= 1'b1;
            busy_r        <= 1'b1;
            state         <= ST_RUN;
          end else if (done_hit || timer_expire) begin
            if (!done_hit) begin
              phase_abort_r <= 1'b1;
              timeout_err_r <= 1'b1;
              err_phase_r   <= phase;
            end
            if (phase == PH_SHOOT) begin
              state <= ST_DONE;
            end else begin
              phase <= next_phase(phase, spawn_pending);
              state <= ST_LAUNCH;
            end
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b1;
          busy_r       <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign seq.phase_start = phase_start_r;
  assign seq.phase_abort = phase_abort_r;
  assign seq.phase_sel   = phase_sel_r;
  assign seq.mem_owner   = mem_owner_r;
  assign seq.busy        = busy_r;
  assign seq.frame_done  = frame_done_r;
  assign seq.timeout_err = timeout_err_r;
  assign seq.err_phase   = err_phase_r;

endmodule

// File: tb/tb_enemy_phase_sequencer.sv
// Bench for enemy_phase_sequencer: directed frame scenarios with randomized engine
// latencies, checked against a frame-level model of the phase schedule.
module tb_enemy_phase_sequencer;

  localparam int TO = 16;
  localparam int SP = 100;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  enemy_phase_sequencer_if ifc ();

  enemy_phase_sequencer #(
    .PHASE_TIMEOUT(TO),
    .SPAWN_PERIOD (SP),
    .CNT_W        (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .seq   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  int cyc           = 0;
  bit m_pending     = 1'b0;
  bit pend_at_clean = 1'b0;
  bit exp_terr      = 1'b0;
  int exp_errph     = 0;

  int dly[4]     = '{3, 3, 3, 3};
  bit resp_en[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  int due[4]     = '{-100, -100, -100, -100};
  int stray_cyc  = -1;

  int st_val[$];
  int st_cyc[$];
  int st_sel[$];
  int st_own[$];
  int abort_cnt  = 0;
  int last_abort = -1;
  int fd_cnt     = 0;
  int last_fd    = -1;

  // Spawn model: a tick every SP cycles since reset; an accepted CREATE done clears it,
  // but a tick on the same edge wins.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc       = 0;
      m_pending = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (ifc.phase_done[0]) pend_at_clean = m_pending;
      if (cyc % SP == 0) m_pending = 1'b1;
      else if (ifc.phase_done[1]) m_pending = 1'b0;
    end
  end

  // Output monitor plus engine models answering start pulses after dly[p] cycles.
  always @(negedge clock) begin
    logic [3:0] done_v;
    if (!reset) begin
      if (ifc.phase_start != 4'b0000) begin
        st_val.push_back(int'(ifc.phase_start));
        st_cyc.push_back(cyc);
        st_sel.push_back(int'(ifc.phase_sel));
        st_own.push_back(int'({ifc.mem_owner, ifc.busy}));
        for (int p = 0; p < 4; p++)
          if (ifc.phase_start[p] && resp_en[p]) due[p] = cyc + dly[p];
      end
      if (ifc.phase_abort) begin abort_cnt++; last_abort = cyc; end
      if (ifc.frame_done)  begin fd_cnt++;    last_fd    = cyc; end
    end
    for (int p = 0; p < 4; p++) done_v[p] = (due[p] == cyc + 1);
    if (stray_cyc == cyc + 1) done_v[3] = 1'b1;
    ifc.phase_done = done_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    st_val.delete(); st_cyc.delete(); st_sel.delete(); st_own.delete();
    for (int p = 0; p < 4; p++) begin
      due[p]     = -100;
      resp_en[p] = 1'b1;
      dly[p]     = int'($urandom_range(1, 6));
    end
    stray_cyc = -1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"},  ifc.phase_start, 0);
    chk({tag, "_abort"},  ifc.phase_abort, 0);
    chk({tag, "_sel"},    ifc.phase_sel,   0);
    chk({tag, "_owner"},  ifc.mem_owner,   0);
    chk({tag, "_busy"},   ifc.busy,        0);
    chk({tag, "_fdone"},  ifc.frame_done,  0);
    chk({tag, "_terr"},   ifc.timeout_err, 0);
    chk({tag, "_errph"},  ifc.err_phase,   0);
  endtask

  // Runs one frame from the current cycle; to_ph is a phase whose engine stays silent
  // (-1 none), d0/d1 force CLEAN/CREATE latencies (0 = random), stray offsets a stray SHOOT done.
  task automatic run_frame(input string tag, input int to_ph, input int d0, input int d1,
                           input int stray);
    int c0, n, t, ab0, fd0, exp_ab, ph;
    int exp_idx[$];
    int exp_cyc[$];
    clear_mon();
    if (to_ph >= 0) resp_en[to_ph] = 1'b0;
    if (d0 > 0) dly[0] = d0;
    if (d1 > 0) dly[1] = d1;
    ab0 = abort_cnt;
    fd0 = fd_cnt;
    c0  = cyc;
    if (stray > 0) stray_cyc = c0 + stray;
    ifc.calc = 1'b1;
    n = 0;
    while (fd_cnt == fd0 && n < 200) begin step(); n++; end
    chk({tag, "_owner_at_fdone"}, ifc.mem_owner, 1);

    exp_idx.push_back(0);
    if (pend_at_clean) exp_idx.push_back(1);
    exp_idx.push_back(2);
    exp_idx.push_back(3);
    t = c0 + 2;
    exp_ab = -1;
    foreach (exp_idx[i]) begin
      exp_cyc.push_back(t);
      ph = exp_idx[i];
      if (ph == to_ph) begin exp_ab = t + TO - 1; t += TO; end
      else t += dly[ph] + 1;
    end

    chk({tag, "_nstarts"}, st_val.size(), exp_idx.size());
    for (int i = 0; i < st_val.size() && i < exp_idx.size(); i++) begin
      chk({tag, "_start_val"}, st_val[i], 1 << exp_idx[i]);
      chk({tag, "_start_cyc"}, st_cyc[i], exp_cyc[i]);
      chk({tag, "_start_sel"}, st_sel[i], exp_idx[i]);
      chk({tag, "_start_own_busy"}, st_own[i], 3);
    end
    chk({tag, "_fdone_cyc"}, last_fd, t);
    chk({tag, "_aborts"}, abort_cnt - ab0, (to_ph >= 0) ? 1 : 0);
    if (to_ph >= 0) begin
      exp_terr  = 1'b1;
      exp_errph = to_ph;
      chk({tag, "_abort_cyc"}, last_abort, exp_ab);
    end
    step();
    chk({tag, "_fdone_cnt"}, fd_cnt - fd0, 1);
    chk({tag, "_owner_after"}, ifc.mem_owner, 0);
    chk({tag, "_busy_after"}, ifc.busy, 0);
    chk({tag, "_terr"}, ifc.timeout_err, exp_terr);
    chk({tag, "_errph"}, ifc.err_phase, exp_errph);
    ifc.calc = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ab0, fd0, f, last_st;
    reset    = 1'b1;
    ifc.calc = 1'b0;
    step(); step();
    chk_quiet("reset");
    reset = 1'b0;

    // 1: no spawn yet, calc rises at cycle 10, CREATE skipped.
    while (cyc < 9) step();
    run_frame("f1", -1, 0, 0, 0);
    chk("f1_len", st_val.size(), 3);

    // 2: after a spawn tick all four phases run; next frame skips CREATE again.
    repeat (100) step();
    run_frame("f2", -1, 0, 0, 0);
    chk("f2_len", st_val.size(), 4);
    run_frame("f2b", -1, 0, 0, 0);
    chk("f2b_len", st_val.size(), 3);

    // 3: MOVE never answers.
    run_frame("f3", 2, 0, 0, 0);

    // 4: calc falls while MOVE is running.
    clear_mon();
    resp_en[2] = 1'b0;
    ab0 = abort_cnt;
    fd0 = fd_cnt;
    ifc.calc = 1'b1;
    n = 0;
    while (!(st_val.size() > 0 && st_val[st_val.size()-1] == 4) && n < 100) begin step(); n++; end
    last_st = (st_val.size() > 0) ? st_val[st_val.size()-1] : 0;
    chk("f4_move_started", last_st, 4);
    repeat (3) step();
    ifc.calc = 1'b0;
    f = cyc;
    step();
    chk("f4_abort_cyc", last_abort, f + 1);
    chk("f4_owner", ifc.mem_owner, 0);
    chk("f4_busy", ifc.busy, 0);
    repeat (10) step();
    chk("f4_aborts", abort_cnt - ab0, 1);
    chk("f4_no_fdone", fd_cnt - fd0, 0);
    last_st = (st_val.size() > 0) ? st_val[st_val.size()-1] : 0;
    chk("f4_no_shoot", last_st, 4);
    run_frame("f4r", -1, 0, 0, 0);

    // 5: CREATE done on a spawn-wrap edge; stray SHOOT done during CLEAN.
    n = 0;
    while (!m_pending && n < 300) begin step(); n++; end
    n = 0;
    while (cyc % SP != 88 && n < 200) begin step(); n++; end
    run_frame("f5", -1, 3, 6, 4);
    chk("f5_len", st_val.size(), 4);
    run_frame("f5b", -1, 0, 0, 0);
    chk("f5b_len", st_val.size(), 4);

    // 6: reset in the middle of CLEAN, calc held high afterwards.
    clear_mon();
    resp_en[0] = 1'b0;
    ifc.calc = 1'b1;
    n = 0;
    while (st_val.size() == 0 && n < 50) begin step(); n++; end
    chk("f6_clean_started", st_val.size(), 1);
    step(); step();
    #2 reset = 1'b1;
    #1 chk_quiet("mid_reset");
    exp_terr  = 1'b0;
    exp_errph = 0;
    step();
    reset = 1'b0;
    clear_mon();
    repeat (20) step();
    chk("f6_no_start", st_val.size(), 0);
    chk("f6_busy", ifc.busy, 0);
    chk("f6_owner", ifc.mem_owner, 0);
    ifc.calc = 1'b0;
    step(); step();
    run_frame("f6r", -1, 0, 0, 0);

    // Randomly spaced frames across spawn ticks.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 150)) step();
      run_frame("rnd", -1, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
